// File: rtl/hc05_rx_if.sv
// hc05_rx_if -- signal bundle between the HC-05 UART receiver and its consumer.
//   rx        : raw UART line from the HC-05 module (idle high, 8N1, LSB first)
//   rd_addr   : message buffer read index
//   rd_data   : buffer byte at rd_addr (8'h00 outside the buffer)
//   rx_data   : last correctly framed byte
//   rx_valid  : one-cycle pulse, rx_data updated
//   frame_err : one-cycle pulse, stop bit sampled low
//   msg_done  : one-cycle pulse, complete message held in the buffer
//   msg_len   : byte count of the last completed message (terminator excluded)
//   msg_err   : one-cycle pulse, terminator arrived after a buffer overflow
// master = receiver side, slave = consumer side.
interface hc05_rx_if;
    logic       rx;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       msg_done;
    logic [3:0] msg_len;
    logic       msg_err;

    modport master (
        input  rx, rd_addr,
        output rd_data, rx_data, rx_valid, frame_err, msg_done, msg_len, msg_err
    );

    modport slave (
        output rx, rd_addr,
        input  rd_data, rx_data, rx_valid, frame_err, msg_done, msg_len, msg_err
    );
endinterface

// File: rtl/hc05_rx.sv
// hc05_rx -- UART 8N1 receiver for an HC-05 Bluetooth module with a small
// terminator-delimited message assembler.
//   clk     : sole clock, rising edge
//   jreset  : synchronous active-high reset
//   bus     : hc05_rx_if.master (rx line in, buffer read port, status pulses out)
// Parameters: CLKS_PER_BIT clocks per bit, MAX_LEN buffer depth (1..15),
// TERM message terminator byte.
module hc05_rx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         MAX_LEN      = 10,
    parameter logic [7:0] TERM         = 8'h23
) (
    input  logic      clk,
    input  logic      jreset,
    hc05_rx_if.master bus
);
    // Counter only ever has to reach CLKS_PER_BIT-1; keep at least 2 bits.
    localparam int            CW      = (CLKS_PER_BIT > 3) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] HALF    = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LEN_MAX = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic          sync1_r;
    logic          rxs_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;
    logic          frame_err_r;

    logic [7:0]    buf_r [MAX_LEN];
    logic [3:0]    wr_ptr_r;
    logic          ovf_r;
    logic [3:0]    msg_len_r;
    logic          msg_done_r;
    logic          msg_err_r;
    logic [7:0]    rd_data_s;
    logic          store_s;

    // Two-flop synchronizer for the asynchronous rx line, idling high.
    always_ff @(posedge clk) begin
        if (jreset) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= bus.rx;
            rxs_r   <= sync1_r;
        end
    end

    // Receive FSM. Cycle 0 is the IDLE cycle that sees the start edge; the
    // counter is loaded with 1 there so that it equals the cycle index while
    // in START, and afterwards runs 0..CLKS_PER_BIT-1 per bit, sampling at the
    // last count so every sample lands in the middle of its bit.
    always_ff @(posedge clk) begin
        if (jreset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            bit_r       <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rxs_r) begin
                        state_r <= START;
                        cnt_r   <= CW'(1);
                        bit_r   <= 3'd0;
                    end
                end
                START: begin
                    if (cnt_r == HALF) begin
                        cnt_r   <= '0;
                        // A line that is high again mid start bit was a glitch.
                        state_r <= rxs_r ? IDLE : DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {rxs_r, shift_r[7:1]};
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == LAST) begin
                        cnt_r <= '0;
                        if (rxs_r) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                BREAK: begin
                    // Wait out a held-low line before hunting for a start bit.
                    if (rxs_r) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // A received byte is stored when it is not the terminator and room remains.
    always_comb begin
        store_s = 1'b0;
        if (rx_valid_r && (rx_data_r != TERM) && (wr_ptr_r < LEN_MAX)) begin
            store_s = 1'b1;
        end else begin
            store_s = 1'b0;
        end
    end

    // Message assembler control: write pointer, overflow flag, result pulses.
    always_ff @(posedge clk) begin
        if (jreset) begin
            wr_ptr_r   <= 4'd0;
            ovf_r      <= 1'b0;
            msg_len_r  <= 4'd0;
            msg_done_r <= 1'b0;
            msg_err_r  <= 1'b0;
        end else begin
            msg_done_r <= 1'b0;
            msg_err_r  <= 1'b0;
            if (frame_err_r) begin
                // A broken frame poisons the message in progress.
                wr_ptr_r <= 4'd0;
                ovf_r    <= 1'b0;
            end else if (rx_valid_r) begin
                if (rx_data_r == TERM) begin
                    if (ovf_r) begin
                        msg_err_r <= 1'b1;
                    end else begin
                        msg_done_r <= 1'b1;
                        msg_len_r  <= wr_ptr_r;
                    end
                    wr_ptr_r <= 4'd0;
                    ovf_r    <= 1'b0;
                end else if (store_s) begin
                    wr_ptr_r <= wr_ptr_r + 4'd1;
                end else begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    // Buffer storage; contents survive reset and completed messages.
    always_ff @(posedge clk) begin
        if (!jreset && store_s) begin
            buf_r[wr_ptr_r] <= rx_data_r;
        end
    end

    // Combinational read port, zero outside the buffer.
    always_comb begin
        rd_data_s = 8'h00;
        if (bus.rd_addr < LEN_MAX) begin
            rd_data_s = buf_r[bus.rd_addr];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    assign bus.rd_data   = rd_data_s;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.msg_done  = msg_done_r;
    assign bus.msg_len   = msg_len_r;
    assign bus.msg_err   = msg_err_r;
endmodule

// File: tb/tb_hc05_rx.sv
// tb_hc05_rx -- directed bench for hc05_rx. One instance runs at the default
// 434 clocks/bit for the single-frame, glitch and mid-frame reset cases; a
// second instance at 24 clocks/bit exercises the message assembler.
module tb_hc05_rx;
    localparam int SLOW_CPB = 434;
    localparam int FAST_CPB = 24;

    logic clk;
    logic jreset_s;
    logic jreset_f;
    int   n_checks;
    int   n_errors;
    int   cyc;

    int         s_valid, s_ferr, s_done, s_merr, s_valid_cyc;
    logic [7:0] s_last;
    int         f_valid, f_ferr, f_done, f_merr;
    logic [7:0] f_last, f_data_at_ferr;

    hc05_rx_if if_s ();
    hc05_rx_if if_f ();

    hc05_rx u_slow (
        .clk    (clk),
        .jreset (jreset_s),
        .bus    (if_s.master)
    );

    hc05_rx #(.CLKS_PER_BIT(FAST_CPB)) u_fast (
        .clk    (clk),
        .jreset (jreset_f),
        .bus    (if_f.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (if_s.rx_valid === 1'b1) begin
            if (s_valid == 0) s_valid_cyc = cyc;
            s_valid = s_valid + 1;
            s_last  = if_s.rx_data;
        end
        if (if_s.frame_err === 1'b1) s_ferr = s_ferr + 1;
        if (if_s.msg_done === 1'b1)  s_done = s_done + 1;
        if (if_s.msg_err === 1'b1)   s_merr = s_merr + 1;
        if (if_f.rx_valid === 1'b1) begin
            f_valid = f_valid + 1;
            f_last  = if_f.rx_data;
        end
        if (if_f.frame_err === 1'b1) begin
            f_ferr         = f_ferr + 1;
            f_data_at_ferr = if_f.rx_data;
        end
        if (if_f.msg_done === 1'b1) f_done = f_done + 1;
        if (if_f.msg_err === 1'b1)  f_merr = f_merr + 1;
    end

    task automatic clear_counts();
        s_valid = 0; s_ferr = 0; s_done = 0; s_merr = 0; s_valid_cyc = 0;
        f_valid = 0; f_ferr = 0; f_done = 0; f_merr = 0;
    endtask

    task automatic send_frame(input bit fast, input logic [7:0] b, input bit stop_bit);
        logic [9:0] bits;
        int         cpb;
        bits = {stop_bit, b, 1'b0};
        cpb  = fast ? FAST_CPB : SLOW_CPB;
        for (int i = 0; i < 10; i++) begin
            if (fast) if_f.rx = bits[i];
            else      if_s.rx = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic send_str_fast(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_frame(1'b1, s[i], 1'b1);
        end
    endtask

    task automatic test_reset();
        jreset_s = 1'b1; jreset_f = 1'b1;
        if_s.rx = 1'b1; if_f.rx = 1'b1;
        if_s.rd_addr = 4'd12; if_f.rd_addr = 4'd0;
        repeat (3) @(negedge clk);
        jreset_s = 1'b0; jreset_f = 1'b0;
        #1;
        n_checks++; if (if_s.rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data got %h exp 00", if_s.rx_data); end
        n_checks++; if (if_s.rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid got %b exp 0", if_s.rx_valid); end
        n_checks++; if (if_s.frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err got %b exp 0", if_s.frame_err); end
        n_checks++; if (if_s.msg_done !== 1'b0 || if_s.msg_err !== 1'b0) begin n_errors++; $display("FAIL reset_msg_pulses got %b%b exp 00", if_s.msg_done, if_s.msg_err); end
        n_checks++; if (if_s.msg_len !== 4'd0) begin n_errors++; $display("FAIL reset_msg_len got %0d exp 0", if_s.msg_len); end
        n_checks++; if (if_s.rd_data !== 8'h00) begin n_errors++; $display("FAIL reset_rd_oob got %h exp 00", if_s.rd_data); end
        n_checks++; if (if_f.rx_data !== 8'h00 || if_f.msg_len !== 4'd0) begin n_errors++; $display("FAIL reset_fast got %h/%0d exp 00/0", if_f.rx_data, if_f.msg_len); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int c0;
        clear_counts();
        c0 = cyc;
        send_frame(1'b0, 8'h46, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++; if (s_valid !== 1) begin n_errors++; $display("FAIL single_valid_count got %0d exp 1", s_valid); end
        n_checks++; if (s_last !== 8'h46) begin n_errors++; $display("FAIL single_rx_data got %h exp 46", s_last); end
        n_checks++; if (s_ferr !== 0) begin n_errors++; $display("FAIL single_frame_err got %0d exp 0", s_ferr); end
        // 2 synchronizer edges + start-edge cycle + 216 + 9*434 = 4125 edges.
        n_checks++;
        if (s_valid == 0 || (s_valid_cyc - c0) < 4124 || (s_valid_cyc - c0) > 4126) begin
            n_errors++; $display("FAIL single_latency got %0d exp 4125", s_valid_cyc - c0);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        if_s.rx = 1'b0;
        repeat (100) @(negedge clk);
        if_s.rx = 1'b1;
        repeat (600) @(negedge clk);
        n_checks++; if (s_valid !== 0 || s_ferr !== 0) begin n_errors++; $display("FAIL glitch_pulses got v%0d f%0d exp v0 f0", s_valid, s_ferr); end
        send_frame(1'b0, 8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++; if (s_valid !== 1 || s_last !== 8'h5A) begin n_errors++; $display("FAIL glitch_recover got %0d/%h exp 1/5a", s_valid, s_last); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        clear_counts();
        bits = {1'b1, 8'h33, 1'b0};
        for (int c = 0; c < 2000; c++) begin
            if_s.rx = bits[c / SLOW_CPB];
            @(negedge clk);
        end
        jreset_s = 1'b1;
        if_s.rx  = 1'b1;
        @(negedge clk);
        jreset_s = 1'b0;
        #1;
        n_checks++; if (if_s.rx_data !== 8'h00) begin n_errors++; $display("FAIL midreset_rx_data got %h exp 00", if_s.rx_data); end
        n_checks++;
        if (if_s.rx_valid !== 1'b0 || if_s.frame_err !== 1'b0 || if_s.msg_done !== 1'b0 || if_s.msg_err !== 1'b0 || if_s.msg_len !== 4'd0) begin
            n_errors++; $display("FAIL midreset_outputs got %b%b%b%b/%0d exp 0000/0", if_s.rx_valid, if_s.frame_err, if_s.msg_done, if_s.msg_err, if_s.msg_len);
        end
        repeat (20) @(negedge clk);
        send_frame(1'b0, 8'h55, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++; if (s_valid !== 1 || s_ferr !== 0) begin n_errors++; $display("FAIL midreset_pulses got v%0d f%0d exp v1 f0", s_valid, s_ferr); end
        n_checks++; if (s_last !== 8'h55) begin n_errors++; $display("FAIL midreset_next_byte got %h exp 55", s_last); end
    endtask

    task automatic test_message();
        string exp_s;
        exp_s = "FIM-CSU1-";
        clear_counts();
        send_str_fast("FIM-CSU1-#");
        repeat (5) @(negedge clk);
        n_checks++; if (f_valid !== 10) begin n_errors++; $display("FAIL msg_valid_count got %0d exp 10", f_valid); end
        n_checks++; if (f_done !== 1 || f_merr !== 0) begin n_errors++; $display("FAIL msg_done_count got d%0d e%0d exp d1 e0", f_done, f_merr); end
        n_checks++; if (if_f.msg_len !== 4'd9) begin n_errors++; $display("FAIL msg_len got %0d exp 9", if_f.msg_len); end
        for (int i = 0; i < 9; i++) begin
            if_f.rd_addr = 4'(i);
            #1;
            n_checks++; if (if_f.rd_data !== exp_s[i]) begin n_errors++; $display("FAIL msg_buf[%0d] got %h exp %h", i, if_f.rd_data, exp_s[i]); end
        end
        if_f.rd_addr = 4'd12;
        #1;
        n_checks++; if (if_f.rd_data !== 8'h00) begin n_errors++; $display("FAIL msg_rd_oob got %h exp 00", if_f.rd_data); end
    endtask

    task automatic test_overflow();
        clear_counts();
        for (int i = 0; i < 12; i++) send_frame(1'b1, 8'h30 + 8'(i), 1'b1);
        send_frame(1'b1, 8'h23, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (f_merr !== 1 || f_done !== 0) begin n_errors++; $display("FAIL ovf_pulses got e%0d d%0d exp e1 d0", f_merr, f_done); end
        n_checks++; if (if_f.msg_len !== 4'd9) begin n_errors++; $display("FAIL ovf_msg_len got %0d exp 9", if_f.msg_len); end
        clear_counts();
        send_str_fast("AB#");
        repeat (5) @(negedge clk);
        n_checks++; if (f_done !== 1 || f_merr !== 0) begin n_errors++; $display("FAIL ab_pulses got d%0d e%0d exp d1 e0", f_done, f_merr); end
        n_checks++; if (if_f.msg_len !== 4'd2) begin n_errors++; $display("FAIL ab_msg_len got %0d exp 2", if_f.msg_len); end
        if_f.rd_addr = 4'd1; #1;
        n_checks++; if (if_f.rd_data !== 8'h42) begin n_errors++; $display("FAIL ab_buf1 got %h exp 42", if_f.rd_data); end
        // Slots past the new message still hold the overflowing message's bytes.
        if_f.rd_addr = 4'd2; #1;
        n_checks++; if (if_f.rd_data !== 8'h32) begin n_errors++; $display("FAIL persist_buf2 got %h exp 32", if_f.rd_data); end
        if_f.rd_addr = 4'd9; #1;
        n_checks++; if (if_f.rd_data !== 8'h39) begin n_errors++; $display("FAIL persist_buf9 got %h exp 39", if_f.rd_data); end
    endtask

    task automatic test_empty_msg();
        clear_counts();
        send_frame(1'b1, 8'h23, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (f_done !== 1 || if_f.msg_len !== 4'd0) begin n_errors++; $display("FAIL empty_msg got d%0d len%0d exp d1 len0", f_done, if_f.msg_len); end
    endtask

    task automatic test_frame_error();
        clear_counts();
        send_str_fast("XY");
        send_frame(1'b1, 8'h41, 1'b0);
        repeat (2000) @(negedge clk);
        if_f.rx = 1'b1;
        repeat (3 * FAST_CPB) @(negedge clk);
        send_frame(1'b1, 8'h42, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (f_ferr !== 1) begin n_errors++; $display("FAIL ferr_count got %0d exp 1", f_ferr); end
        n_checks++; if (f_data_at_ferr !== 8'h59) begin n_errors++; $display("FAIL ferr_rx_data_held got %h exp 59", f_data_at_ferr); end
        n_checks++; if (f_valid !== 3 || f_last !== 8'h42) begin n_errors++; $display("FAIL ferr_valid got %0d/%h exp 3/42", f_valid, f_last); end
        send_frame(1'b1, 8'h23, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (f_done !== 1 || if_f.msg_len !== 4'd1) begin n_errors++; $display("FAIL ferr_discard got d%0d len%0d exp d1 len1", f_done, if_f.msg_len); end
        if_f.rd_addr = 4'd0; #1;
        n_checks++; if (if_f.rd_data !== 8'h42) begin n_errors++; $display("FAIL ferr_buf0 got %h exp 42", if_f.rd_data); end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        clear_counts();
        s_last = 8'h00; f_last = 8'h00; f_data_at_ferr = 8'h00;
        jreset_s = 1'b1; jreset_f = 1'b1;
        if_s.rx = 1'b1; if_f.rx = 1'b1;
        if_s.rd_addr = 4'd0; if_f.rd_addr = 4'd0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_glitch();
        test_reset_midframe();
        test_message();
        test_overflow();
        test_empty_msg();
        test_frame_error();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
